// File: rtl/ad9364_pkg.sv
// Shared types and default constants for the AD9364 FDD stream controller.
// State encodings are visible to software through state_o and must not be renumbered.
package ad9364_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PIN_ON  = 3'd1,
    ST_RUN     = 3'd2,
    ST_DP_OFF  = 3'd3,
    ST_PIN_OFF = 3'd4
  } state_t;

  localparam int unsigned DEF_LEVEL_W         = 11;
  localparam int unsigned DEF_FIFO_DEPTH      = 1024;
  localparam int unsigned DEF_TX_START_THRESH = 256;
  localparam int unsigned DEF_RX_HEADROOM     = 4;
  localparam int unsigned DEF_SETTLE_CYCLES   = 64;
  localparam int unsigned DEF_CNT_W           = 16;

endpackage

// File: rtl/ad9364_stream_ctrl_if.sv
// Controller <-> device-interface signals: ENSM pins, datapath enables, TX feedback.
interface ad9364_stream_ctrl_if;

  logic ensm_enable;
  logic ensm_txnrx;
  logic enable_datapath;
  logic rx_write_allowed;
  logic tx_start_allowed;
  logic tx_read_allowed;
  logic tx_enable_fb;

  modport master (
    output ensm_enable,
    output ensm_txnrx,
    output enable_datapath,
    output rx_write_allowed,
    output tx_start_allowed,
    output tx_read_allowed,
    input  tx_enable_fb
  );

  modport slave (
    input  ensm_enable,
    input  ensm_txnrx,
    input  enable_datapath,
    input  rx_write_allowed,
    input  tx_start_allowed,
    input  tx_read_allowed,
    output tx_enable_fb
  );

endinterface

// File: rtl/sat_event_counter.sv
// Counts qualified falling edges of sig, saturating at all-ones; clr wins over an event.
module sat_event_counter #(
  parameter int unsigned W = 16
) (
  input  logic         l_clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         sig,
  input  logic         qual,
  output logic [W-1:0] count
);

  logic         sig_prev_r;
  logic [W-1:0] count_r;
  logic         event_s;
  logic         at_max_s;

  assign event_s  = qual & sig_prev_r & ~sig;
  assign at_max_s = (count_r == {W{1'b1}});
  assign count    = count_r;

  // Edge history and saturating count register
  always_ff @(posedge l_clk) begin
    if (!rst_n) begin
      sig_prev_r <= 1'b0;
      count_r    <= {W{1'b0}};
    end else begin
      sig_prev_r <= sig;
      if (clr) begin
        count_r <= {W{1'b0}};
      end else if (event_s && !at_max_s) begin
        count_r <= count_r + W'(1);
      end else begin
        count_r <= count_r;
      end
    end
  end

endmodule

// File: rtl/ad9364_stream_ctrl.sv
// AD9364 ENSM pin and datapath-enable sequencer for FDD streaming, with
// FIFO watermarks and saturating RX overflow / TX underrun event counters.
module ad9364_stream_ctrl
  import ad9364_pkg::*;
#(
  parameter int unsigned LEVEL_W         = DEF_LEVEL_W,
  parameter int unsigned FIFO_DEPTH      = DEF_FIFO_DEPTH,
  parameter int unsigned TX_START_THRESH = DEF_TX_START_THRESH,
  parameter int unsigned RX_HEADROOM     = DEF_RX_HEADROOM,
  parameter int unsigned SETTLE_CYCLES   = DEF_SETTLE_CYCLES,
  parameter int unsigned CNT_W           = DEF_CNT_W
) (
  input  logic                 l_clk,
  input  logic                 rst_n,
  input  logic                 cmd_stream,
  input  logic                 cmd_tx_en,
  input  logic                 cmd_rx_en,
  input  logic                 clr_counters,
  input  logic [LEVEL_W-1:0]   rx_fifo_level,
  input  logic [LEVEL_W-1:0]   tx_fifo_level,
  ad9364_stream_ctrl_if.master dev,
  output logic                 busy,
  output logic [2:0]           state_o,
  output logic [CNT_W-1:0]     rx_overflow_cnt,
  output logic [CNT_W-1:0]     tx_underrun_cnt
);

  localparam int unsigned        SET_W       = $clog2(SETTLE_CYCLES + 1);
  localparam logic [SET_W-1:0]   SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [LEVEL_W-1:0] RX_LIMIT    = LEVEL_W'(FIFO_DEPTH - RX_HEADROOM);
  localparam logic [LEVEL_W-1:0] TX_THRESH   = LEVEL_W'(TX_START_THRESH);
  // Two words cover the output register plus the read-enable pipeline
  localparam logic [LEVEL_W-1:0] TX_RD_MIN   = LEVEL_W'(2);

  state_t             state_r, state_s;
  logic [SET_W-1:0]   settle_r, settle_s;
  logic               settle_done_s;
  logic               ensm_enable_r, ensm_enable_s;
  logic               ensm_txnrx_r, ensm_txnrx_s;
  logic               dp_r, dp_s;
  logic               rxw_r, rxw_s;
  logic               txs_r, txs_s;
  logic               txr_r, txr_s;
  logic               busy_r;
  logic               rx_level_ok_s;
  logic               rx_ovf_qual_s;
  logic               tx_unr_qual_s;

  assign settle_done_s = (settle_r == SETTLE_LAST);
  assign rx_level_ok_s = (rx_fifo_level < RX_LIMIT);

  // Next-state, settle timer and pin/enable targets
  always_comb begin
    state_s       = state_r;
    settle_s      = settle_r;
    ensm_enable_s = ensm_enable_r;
    ensm_txnrx_s  = ensm_txnrx_r;
    dp_s          = dp_r;
    case (state_r)
      ST_IDLE: begin
        if (cmd_stream) begin
          state_s       = ST_PIN_ON;
          settle_s      = {SET_W{1'b0}};
          ensm_enable_s = 1'b1;
          ensm_txnrx_s  = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_PIN_ON: begin
        if (!cmd_stream) begin
          state_s       = ST_PIN_OFF;
          settle_s      = {SET_W{1'b0}};
          ensm_enable_s = 1'b0;
        end else if (settle_done_s) begin
          state_s  = ST_RUN;
          settle_s = {SET_W{1'b0}};
          dp_s     = 1'b1;
        end else begin
          settle_s = settle_r + SET_W'(1);
        end
      end
      ST_RUN: begin
        if (!cmd_stream) begin
          state_s  = ST_DP_OFF;
          settle_s = {SET_W{1'b0}};
          dp_s     = 1'b0;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_DP_OFF: begin
        if (settle_done_s) begin
          state_s       = ST_PIN_OFF;
          settle_s      = {SET_W{1'b0}};
          ensm_enable_s = 1'b0;
        end else begin
          settle_s = settle_r + SET_W'(1);
        end
      end
      ST_PIN_OFF: begin
        if (settle_done_s) begin
          state_s      = ST_IDLE;
          settle_s     = {SET_W{1'b0}};
          ensm_txnrx_s = 1'b0;
        end else begin
          settle_s = settle_r + SET_W'(1);
        end
      end
      default: begin
        state_s       = ST_IDLE;
        settle_s      = {SET_W{1'b0}};
        ensm_enable_s = 1'b0;
        ensm_txnrx_s  = 1'b0;
        dp_s          = 1'b0;
      end
    endcase
  end

  // Watermarks only open while the next state is RUN
  always_comb begin
    rxw_s = 1'b0;
    txs_s = 1'b0;
    txr_s = 1'b0;
    if (state_s == ST_RUN) begin
      rxw_s = cmd_rx_en & rx_level_ok_s;
      txs_s = cmd_tx_en & (tx_fifo_level >= TX_THRESH);
      txr_s = cmd_tx_en & (tx_fifo_level > TX_RD_MIN);
    end else begin
      rxw_s = 1'b0;
      txs_s = 1'b0;
      txr_s = 1'b0;
    end
  end

  // State, timer and output registers
  always_ff @(posedge l_clk) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      settle_r      <= {SET_W{1'b0}};
      ensm_enable_r <= 1'b0;
      ensm_txnrx_r  <= 1'b0;
      dp_r          <= 1'b0;
      rxw_r         <= 1'b0;
      txs_r         <= 1'b0;
      txr_r         <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      state_r       <= state_s;
      settle_r      <= settle_s;
      ensm_enable_r <= ensm_enable_s;
      ensm_txnrx_r  <= ensm_txnrx_s;
      dp_r          <= dp_s;
      rxw_r         <= rxw_s;
      txs_r         <= txs_s;
      txr_r         <= txr_s;
      busy_r        <= (state_s != ST_IDLE);
    end
  end

  // A fall of rx_write_allowed counts only when the level, not a stop or rx disable, causes it
  assign rx_ovf_qual_s = (state_r == ST_RUN) & cmd_stream & cmd_rx_en & rxw_r;
  assign tx_unr_qual_s = (state_r == ST_RUN) & cmd_stream & cmd_tx_en;

  sat_event_counter #(.W(CNT_W)) u_rx_ovf (
    .l_clk (l_clk),
    .rst_n (rst_n),
    .clr   (clr_counters),
    .sig   (rx_level_ok_s),
    .qual  (rx_ovf_qual_s),
    .count (rx_overflow_cnt)
  );

  sat_event_counter #(.W(CNT_W)) u_tx_unr (
    .l_clk (l_clk),
    .rst_n (rst_n),
    .clr   (clr_counters),
    .sig   (dev.tx_enable_fb),
    .qual  (tx_unr_qual_s),
    .count (tx_underrun_cnt)
  );

  assign dev.ensm_enable      = ensm_enable_r;
  assign dev.ensm_txnrx       = ensm_txnrx_r;
  assign dev.enable_datapath  = dp_r;
  assign dev.rx_write_allowed = rxw_r;
  assign dev.tx_start_allowed = txs_r;
  assign dev.tx_read_allowed  = txr_r;
  assign busy                 = busy_r;
  assign state_o              = state_r;

endmodule

// File: tb/tb_ad9364_stream_ctrl.sv
// Directed + randomized bench for ad9364_stream_ctrl against a cycle-level behavioural model.
module tb_ad9364_stream_ctrl;

  localparam int SETTLE   = 64;
  localparam int RX_LIMIT = 1024 - 4;
  localparam int TX_TH    = 256;
  localparam int CNT_MAX  = 65535;
  localparam int SC_MAX   = 15;

  logic        l_clk = 1'b0;
  logic        rst_n;
  logic        cmd_stream, cmd_tx_en, cmd_rx_en, clr_counters;
  logic [10:0] rx_fifo_level, tx_fifo_level;
  logic        busy;
  logic [2:0]  state_o;
  logic [15:0] rx_overflow_cnt, tx_underrun_cnt;
  logic        sc_clr, sc_sig, sc_qual;
  logic [3:0]  sc_count;

  int checks = 0;
  int errors = 0;

  // Model: phase = spec state number, age = cycles spent in the current phase
  int m_phase, m_age, exp_rx_cnt, exp_tx_cnt, exp_sc;
  bit exp_rxw, exp_txs, exp_txr, m_fb_prev, m_sc_prev;

  always #5 l_clk = ~l_clk;

  ad9364_stream_ctrl_if dev_if ();

  ad9364_stream_ctrl dut (
    .l_clk           (l_clk),
    .rst_n           (rst_n),
    .cmd_stream      (cmd_stream),
    .cmd_tx_en       (cmd_tx_en),
    .cmd_rx_en       (cmd_rx_en),
    .clr_counters    (clr_counters),
    .rx_fifo_level   (rx_fifo_level),
    .tx_fifo_level   (tx_fifo_level),
    .dev             (dev_if),
    .busy            (busy),
    .state_o         (state_o),
    .rx_overflow_cnt (rx_overflow_cnt),
    .tx_underrun_cnt (tx_underrun_cnt)
  );

  // Narrow stand-alone counter so saturation is reachable in a short run
  sat_event_counter #(.W(4)) u_sc (
    .l_clk (l_clk),
    .rst_n (rst_n),
    .clr   (sc_clr),
    .sig   (sc_sig),
    .qual  (sc_qual),
    .count (sc_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    bit rx_ev, tx_ev, sc_ev;
    @(posedge l_clk);
    sc_ev = sc_qual && m_sc_prev && !sc_sig;
    if (!rst_n) begin
      m_phase = 0; m_age = 0; exp_rx_cnt = 0; exp_tx_cnt = 0; exp_sc = 0;
      exp_rxw = 0; exp_txs = 0; exp_txr = 0; m_fb_prev = 0; m_sc_prev = 0;
    end else begin
      rx_ev = (m_phase == 2) && cmd_stream && cmd_rx_en && exp_rxw && (int'(rx_fifo_level) >= RX_LIMIT);
      tx_ev = (m_phase == 2) && cmd_stream && cmd_tx_en && m_fb_prev && !dev_if.tx_enable_fb;
      case (m_phase)
        0: if (cmd_stream) begin m_phase = 1; m_age = 0; end
        1: if (!cmd_stream) begin m_phase = 4; m_age = 0; end
           else if (m_age == SETTLE - 1) begin m_phase = 2; m_age = 0; end
           else m_age++;
        2: if (!cmd_stream) begin m_phase = 3; m_age = 0; end
        default: if (m_age == SETTLE - 1) begin m_phase = (m_phase == 3) ? 4 : 0; m_age = 0; end
                 else m_age++;
      endcase
      exp_rxw = (m_phase == 2) && cmd_rx_en && (int'(rx_fifo_level) < RX_LIMIT);
      exp_txs = (m_phase == 2) && cmd_tx_en && (int'(tx_fifo_level) >= TX_TH);
      exp_txr = (m_phase == 2) && cmd_tx_en && (int'(tx_fifo_level) > 2);
      if (clr_counters) begin exp_rx_cnt = 0; exp_tx_cnt = 0; end
      else begin
        if (rx_ev && exp_rx_cnt < CNT_MAX) exp_rx_cnt++;
        if (tx_ev && exp_tx_cnt < CNT_MAX) exp_tx_cnt++;
      end
      if (sc_clr) exp_sc = 0;
      else if (sc_ev && exp_sc < SC_MAX) exp_sc++;
      m_fb_prev = dev_if.tx_enable_fb;
      m_sc_prev = sc_sig;
    end
    #1;
    chk("state_o", state_o, m_phase);
    chk("busy", busy, m_phase != 0);
    chk("ensm_enable", dev_if.ensm_enable, m_phase >= 1 && m_phase <= 3);
    chk("ensm_txnrx", dev_if.ensm_txnrx, m_phase != 0);
    chk("enable_datapath", dev_if.enable_datapath, m_phase == 2);
    chk("rx_write_allowed", dev_if.rx_write_allowed, exp_rxw);
    chk("tx_start_allowed", dev_if.tx_start_allowed, exp_txs);
    chk("tx_read_allowed", dev_if.tx_read_allowed, exp_txr);
    chk("rx_overflow_cnt", rx_overflow_cnt, exp_rx_cnt);
    chk("tx_underrun_cnt", tx_underrun_cnt, exp_tx_cnt);
    chk("sat_cnt", sc_count, exp_sc);
    sc_sig  = 1'($urandom);
    sc_qual = ($urandom_range(0, 3) != 0);
    sc_clr  = ($urandom_range(0, 149) == 0);
  endtask

  initial begin
    int rx_seq[4];
    rx_seq = '{1019, 1020, 1019, 1020};
    rst_n = 1'b0; cmd_stream = 1'b0; cmd_tx_en = 1'b0; cmd_rx_en = 1'b0; clr_counters = 1'b0;
    rx_fifo_level = 11'd0; tx_fifo_level = 11'd0; dev_if.tx_enable_fb = 1'b0;
    sc_clr = 1'b0; sc_sig = 1'b0; sc_qual = 1'b0;
    m_phase = 0; m_age = 0; exp_rx_cnt = 0; exp_tx_cnt = 0; exp_sc = 0;
    exp_rxw = 0; exp_txs = 0; exp_txr = 0; m_fb_prev = 0; m_sc_prev = 0;

    repeat (3) tick();
    chk("reset_state", state_o, 3'd0);

    // Start: pins at cycle 1, datapath at cycle 65
    rst_n = 1'b1; cmd_stream = 1'b1;
    tick();
    chk("start_enable", dev_if.ensm_enable, 1'b1);
    chk("start_txnrx", dev_if.ensm_txnrx, 1'b1);
    repeat (63) tick();
    chk("dp_before_65", dev_if.enable_datapath, 1'b0);
    tick();
    chk("dp_at_65", dev_if.enable_datapath, 1'b1);
    chk("run_state", state_o, 3'd2);

    // TX watermark ramp
    cmd_tx_en = 1'b1; dev_if.tx_enable_fb = 1'b1;
    for (int lvl = 0; lvl <= 300; lvl++) begin
      tx_fifo_level = 11'(lvl);
      tick();
      if (lvl == 2)   chk("txr_at_2", dev_if.tx_read_allowed, 1'b0);
      if (lvl == 3)   chk("txr_at_3", dev_if.tx_read_allowed, 1'b1);
      if (lvl == 255) chk("txs_at_255", dev_if.tx_start_allowed, 1'b0);
      if (lvl == 256) chk("txs_at_256", dev_if.tx_start_allowed, 1'b1);
    end
    tx_fifo_level = 11'd2;
    tick();
    chk("txr_drop_2", dev_if.tx_read_allowed, 1'b0);
    dev_if.tx_enable_fb = 1'b0;
    repeat (2) tick();
    chk("underrun_1", tx_underrun_cnt, 16'd1);

    // RX overflow edges; holding full adds nothing
    cmd_rx_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rx_fifo_level = 11'(rx_seq[i]);
      repeat (3) tick();
    end
    chk("rx_ovf_2", rx_overflow_cnt, 16'd2);
    repeat (100) tick();
    chk("rx_ovf_hold", rx_overflow_cnt, 16'd2);

    // Randomized run traffic
    for (int i = 0; i < 400; i++) begin
      rx_fifo_level = 11'($urandom_range(1012, 1030));
      tx_fifo_level = 11'($urandom_range(0, 300));
      cmd_rx_en = ($urandom_range(0, 7) != 0);
      cmd_tx_en = ($urandom_range(0, 7) != 0);
      dev_if.tx_enable_fb = 1'($urandom);
      clr_counters = ($urandom_range(0, 99) == 0);
      tick();
    end
    clr_counters = 1'b0;

    // Clear coincident with an underrun event
    cmd_tx_en = 1'b1; dev_if.tx_enable_fb = 1'b1;
    tick();
    dev_if.tx_enable_fb = 1'b0; clr_counters = 1'b1;
    tick();
    chk("clr_priority", tx_underrun_cnt, 16'd0);
    clr_counters = 1'b0;

    // Stop sequence; a new start request in PIN_OFF waits for IDLE
    cmd_stream = 1'b0;
    tick();
    chk("stop_dp", dev_if.enable_datapath, 1'b0);
    chk("stop_rxw", dev_if.rx_write_allowed, 1'b0);
    repeat (63) tick();
    chk("stop_en_held", dev_if.ensm_enable, 1'b1);
    tick();
    chk("stop_en_off", dev_if.ensm_enable, 1'b0);
    cmd_stream = 1'b1;
    repeat (63) tick();
    chk("pin_off_held", state_o, 3'd4);
    tick();
    chk("stop_txnrx_off", dev_if.ensm_txnrx, 1'b0);
    chk("stop_busy", busy, 1'b0);

    // Abort during PIN_ON at cycle 10
    tick();
    repeat (10) tick();
    cmd_stream = 1'b0;
    tick();
    chk("abort_pin_off", state_o, 3'd4);
    repeat (64) tick();
    chk("abort_idle", state_o, 3'd0);

    // Reset while running
    cmd_stream = 1'b1;
    repeat (65) tick();
    chk("rerun_state", state_o, 3'd2);
    rst_n = 1'b0;
    tick();
    chk("rst_run_en", dev_if.ensm_enable, 1'b0);
    chk("rst_run_dp", dev_if.enable_datapath, 1'b0);
    rst_n = 1'b1; cmd_stream = 1'b0;
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
